// File: rtl/dbus_master_seq.sv
// dbus_master_seq
//   Queued data-bus master. Commands (read/write, address, data) go into a
//   small FIFO and are replayed as single-strobe dbus cycles with a
//   programmable address setup time. Read data is returned through a
//   valid/ready response slot. A read that finds the slot still occupied
//   keeps its address on the bus until the slot frees.
//
//   Optional feature (compile-time macro DBUS_AUTOINC_EN): every command
//   carries a repeat count (CmdCount = burst length - 1). The access then
//   repeats with the address stepping by one modulo 2^ADDR_WIDTH. When the
//   macro is undefined, the CNT_WIDTH parameter, the CmdCount port and the
//   FIFO count field are all absent.
//
// Parameters
//   DATA_WIDTH    bus data width
//   ADDR_WIDTH    bus address width
//   CMD_DEPTH     command FIFO depth (power of 2, >= 2)
//   SETUP_CYCLES  cycles Addr/Dout are stable before strobe/sample (>= 1)
//   CNT_WIDTH     burst count width (DBUS_AUTOINC_EN only)
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst_n     in   asynchronous reset, active low
//   CmdValid  in   command offered
//   CmdReady  out  FIFO can accept a command
//   CmdWr     in   1 = write, 0 = read
//   CmdAddr   in   target address
//   CmdData   in   write data (ignored for reads)
//   CmdCount  in   extra repetitions (DBUS_AUTOINC_EN only)
//   RspValid  out  read data available
//   RspReady  in   consumer accepts read data
//   RspData   out  read data
//   Busy      out  FIFO not empty or sequencer active
//   Addr      out  bus address
//   Dout      out  bus write data
//   Din       in   bus read data
//   Wr        out  bus write strobe
module dbus_master_seq #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int CMD_DEPTH    = 4,
   parameter int SETUP_CYCLES = 1
`ifdef DBUS_AUTOINC_EN
   ,
   parameter int CNT_WIDTH    = 4
`endif
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  CmdValid,
   output logic                  CmdReady,
   input  logic                  CmdWr,
   input  logic [ADDR_WIDTH-1:0] CmdAddr,
   input  logic [DATA_WIDTH-1:0] CmdData,
`ifdef DBUS_AUTOINC_EN
   input  logic [CNT_WIDTH-1:0]  CmdCount,
`endif
   output logic                  RspValid,
   input  logic                  RspReady,
   output logic [DATA_WIDTH-1:0] RspData,
   output logic                  Busy,
   output logic [ADDR_WIDTH-1:0] Addr,
   output logic [DATA_WIDTH-1:0] Dout,
   input  logic [DATA_WIDTH-1:0] Din,
   output logic                  Wr
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETUP_CYCLES - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(CMD_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE
   } state_t;

   // command FIFO storage
   logic                  fifo_wr   [CMD_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [CMD_DEPTH];
`ifdef DBUS_AUTOINC_EN
   logic [CNT_WIDTH-1:0]  fifo_cnt  [CMD_DEPTH];
   logic [CNT_WIDTH-1:0]  rem_q, rem_n;
`endif

   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count_q, count_n;
   logic                  push, pop;

   state_t                state_q, state_n;
   logic [SET_W-1:0]      setup_q, setup_n;
   logic                  is_wr_q, is_wr_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [DATA_WIDTH-1:0] dout_q, dout_n;
   logic                  wr_q, wr_n;
   logic                  rsp_valid_q, rsp_valid_n;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_n;
   logic                  busy_q, busy_n;
   logic                  cmd_ready_q, cmd_ready_n;
   logic                  more;

   // CmdReady is a flop, so a pop on a full FIFO cannot admit a push
   // in the same cycle.
   assign push = CmdValid && cmd_ready_q;

`ifdef DBUS_AUTOINC_EN
   assign more = (rem_q != '0);
`else
   assign more = 1'b0;
`endif

   // Next-state and datapath
   always_comb begin
      state_n     = state_q;
      setup_n     = setup_q;
      is_wr_n     = is_wr_q;
      addr_n      = addr_q;
      dout_n      = dout_q;
      wr_n        = 1'b0;
      rsp_valid_n = rsp_valid_q && !RspReady;
      rsp_data_n  = rsp_data_q;
      pop         = 1'b0;
`ifdef DBUS_AUTOINC_EN
      rem_n       = rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            addr_n = '0;
            dout_n = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_n = S_SETUP;
               setup_n = SET_LOAD;
               is_wr_n = fifo_wr[rd_ptr];
               addr_n  = fifo_addr[rd_ptr];
               dout_n  = fifo_wr[rd_ptr] ? fifo_data[rd_ptr] : '0;
`ifdef DBUS_AUTOINC_EN
               rem_n   = fifo_cnt[rd_ptr];
`endif
            end
         end
         S_SETUP: begin
            if (setup_q != '0) begin
               setup_n = setup_q - SET_W'(1);
            end else if (is_wr_q) begin
               wr_n    = 1'b1;
               state_n = S_STROBE;
            end else if (!rsp_valid_q || RspReady) begin
               // sample only when the response slot is free or being
               // consumed at this same edge; otherwise hold the address
               rsp_valid_n = 1'b1;
               rsp_data_n  = Din;
               if (more) begin
                  addr_n  = addr_q + ADDR_WIDTH'(1);
                  setup_n = SET_LOAD;
`ifdef DBUS_AUTOINC_EN
                  rem_n   = rem_q - CNT_WIDTH'(1);
`endif
               end else begin
                  addr_n  = '0;
                  state_n = S_IDLE;
               end
            end
         end
         S_STROBE: begin
            if (more) begin
               // next burst beat goes straight back to setup, Wr low
               addr_n  = addr_q + ADDR_WIDTH'(1);
               setup_n = SET_LOAD;
               state_n = S_SETUP;
`ifdef DBUS_AUTOINC_EN
               rem_n   = rem_q - CNT_WIDTH'(1);
`endif
            end else begin
               addr_n  = '0;
               dout_n  = '0;
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_comb begin
      count_n = count_q;
      if (push && !pop) begin
         count_n = count_q + (PTR_W + 1)'(1);
      end else if (!push && pop) begin
         count_n = count_q - (PTR_W + 1)'(1);
      end
   end

   assign busy_n      = (state_n != S_IDLE) || (count_n != '0);
   assign cmd_ready_n = (count_n != FIFO_FULL);

   // State and control registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= S_IDLE;
         setup_q     <= '0;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
`ifdef DBUS_AUTOINC_EN
         rem_q       <= '0;
`endif
      end else begin
         state_q     <= state_n;
         setup_q     <= setup_n;
         is_wr_q     <= is_wr_n;
         addr_q      <= addr_n;
         dout_q      <= dout_n;
         wr_q        <= wr_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_data_q  <= rsp_data_n;
         busy_q      <= busy_n;
         cmd_ready_q <= cmd_ready_n;
         count_q     <= count_n;
`ifdef DBUS_AUTOINC_EN
         rem_q       <= rem_n;
`endif
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // FIFO payload needs no reset; occupancy is tracked by count_q
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_wr[wr_ptr]   <= CmdWr;
         fifo_addr[wr_ptr] <= CmdAddr;
         fifo_data[wr_ptr] <= CmdData;
`ifdef DBUS_AUTOINC_EN
         fifo_cnt[wr_ptr]  <= CmdCount;
`endif
      end
   end

   assign CmdReady = cmd_ready_q;
   assign RspValid = rsp_valid_q;
   assign RspData  = rsp_data_q;
   assign Busy     = busy_q;
   assign Addr     = addr_q;
   assign Dout     = dout_q;
   assign Wr       = wr_q;

endmodule

// File: tb/tb_dbus_master_seq.sv
// Bench for dbus_master_seq: directed protocol steps plus a randomized
// command stream. A slave register bank answers Din from Addr and accepts
// strobed writes. The reference model executes commands in order against a
// shadow memory and predicts the strobe log and the response log.
module tb_dbus_master_seq;
   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int SETUP = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
`ifdef DBUS_AUTOINC_EN
   logic [3:0]    cmd_count;
`endif
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          busy;
   logic [AW-1:0] addr;
   logic [DW-1:0] dout, din;
   logic          wr;

   int            errors = 0;
   int            checks = 0;
   logic          rand_ready = 1'b0;

   logic [DW-1:0] slave_mem [256];
   logic [DW-1:0] model_mem [256];
   logic [DW-1:0] snap_mem  [256];
   logic [15:0]   wr_log[$];
   logic [15:0]   exp_wr[$];
   logic [7:0]    rsp_log[$];
   logic [7:0]    exp_rsp[$];

   int            wr_double = 0;
   int            rsp_drop  = 0;
   logic          wr_prev   = 1'b0;
   logic          hold_pend = 1'b0;
   logic [7:0]    hold_data = '0;

   always #5 clk = ~clk;

   dbus_master_seq #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .CMD_DEPTH   (DEPTH),
      .SETUP_CYCLES(SETUP)
`ifdef DBUS_AUTOINC_EN
      ,
      .CNT_WIDTH   (4)
`endif
   ) dut (
      .Clk     (clk),
      .Rst_n   (rst_n),
      .CmdValid(cmd_valid),
      .CmdReady(cmd_ready),
      .CmdWr   (cmd_wr),
      .CmdAddr (cmd_addr),
      .CmdData (cmd_data),
`ifdef DBUS_AUTOINC_EN
      .CmdCount(cmd_count),
`endif
      .RspValid(rsp_valid),
      .RspReady(rsp_ready),
      .RspData (rsp_data),
      .Busy    (busy),
      .Addr    (addr),
      .Dout    (dout),
      .Din     (din),
      .Wr      (wr)
   );

   function automatic logic [7:0] init_val(input int unsigned a);
      return 8'(a) ^ 8'h7C;
   endfunction

   // slave register bank
   initial begin
      for (int i = 0; i < 256; i++) slave_mem[i] = init_val(i);
   end
   always @(posedge clk) begin
      if (rst_n && wr) slave_mem[addr] <= dout;
   end
   assign din = slave_mem[addr];

   // bus / response monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         wr_prev   <= 1'b0;
         hold_pend <= 1'b0;
      end else begin
         if (wr) wr_log.push_back({addr, dout});
         if (wr && wr_prev) wr_double <= wr_double + 1;
         if (hold_pend && (!rsp_valid || rsp_data !== hold_data)) rsp_drop <= rsp_drop + 1;
         if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
         wr_prev   <= wr;
         hold_pend <= rsp_valid && !rsp_ready;
         hold_data <= rsp_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   // reference model: in-order execution against a shadow memory
   task automatic model_exec(input logic w, input logic [7:0] a, input logic [7:0] d);
      if (w) begin
         model_mem[a] = d;
         exp_wr.push_back({a, d});
      end else begin
         exp_rsp.push_back(model_mem[a]);
      end
   endtask

   task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
      int unsigned g = 0;
      cmd_valid = 1'b1;
      cmd_wr    = w;
      cmd_addr  = a;
      cmd_data  = d;
      while (!cmd_ready && g < 200) begin
         tick();
         g++;
      end
      chk("push_wait", 32'(g < 200), 1);
      tick();
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
   endtask

   task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
      send(w, a, d);
      model_exec(w, a, d);
   endtask

`ifdef DBUS_AUTOINC_EN
   task automatic push_burst(input logic w, input logic [7:0] a, input logic [7:0] d,
                             input logic [3:0] n);
      cmd_count = n;
      send(w, a, d);
      cmd_count = '0;
      for (int r = 0; r <= int'(n); r++) model_exec(w, 8'(int'(a) + r), d);
   endtask
`endif

   task automatic drain(input string tag);
      int unsigned g = 0;
      rand_ready = 1'b0;
      rsp_ready  = 1'b1;
      while ((busy || rsp_valid) && g < 1000) begin
         tick();
         g++;
      end
      chk({tag, "_drain"}, 32'(g < 1000), 1);
      repeat (2) tick();
   endtask

   task automatic check_logs(input string tag);
      chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
      chk({tag, "_rsp_count"}, rsp_log.size(), exp_rsp.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
      for (int i = 0; i < exp_rsp.size() && i < rsp_log.size(); i++)
         chk($sformatf("%s_rsp%0d", tag, i), 32'(rsp_log[i]), 32'(exp_rsp[i]));
      wr_log.delete();
      rsp_log.delete();
      exp_wr.delete();
      exp_rsp.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      rsp_ready = 1'b0;
`ifdef DBUS_AUTOINC_EN
      cmd_count = '0;
`endif

      // reset state
      #3;
      chk("rst_addr", addr, 0);
      chk("rst_dout", dout, 0);
      chk("rst_wr", wr, 0);
      chk("rst_rspvalid", rsp_valid, 0);
      chk("rst_rspdata", rsp_data, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rel_cmdready", cmd_ready, 1);
      chk("rel_busy", busy, 0);

      // single write
      rsp_ready = 1'b1;
      push(1'b1, 8'h12, 8'hA5);
      tick();
      chk("w_setup_addr", addr, 8'h12);
      chk("w_setup_dout", dout, 8'hA5);
      chk("w_setup_wr", wr, 0);
      chk("w_setup_busy", busy, 1);
      tick();
      chk("w_strobe_addr", addr, 8'h12);
      chk("w_strobe_dout", dout, 8'hA5);
      chk("w_strobe_wr", wr, 1);
      tick();
      chk("w_end_addr", addr, 0);
      chk("w_end_dout", dout, 0);
      chk("w_end_wr", wr, 0);
      chk("w_end_busy", busy, 0);

      // single read at 0x40 (slave holds 0x3C)
      push(1'b0, 8'h40, 8'h00);
      tick();
      chk("r_setup_addr", addr, 8'h40);
      chk("r_setup_valid", rsp_valid, 0);
      tick();
      chk("r_rsp_valid", rsp_valid, 1);
      chk("r_rsp_data", rsp_data, 8'h3C);
      chk("r_rsp_addr", addr, 0);
      chk("r_rsp_wr", wr, 0);
      tick();
      chk("r_rsp_done", rsp_valid, 0);

      // back-pressure: two reads, consumer stalled
      rsp_ready = 1'b0;
      push(1'b0, 8'h50, 8'h00);
      push(1'b0, 8'h51, 8'h00);
      repeat (6) tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 8'h2C);
      chk("bp_hold_addr", addr, 8'h51);
      chk("bp_hold_busy", busy, 1);
      rsp_ready = 1'b1;
      tick();
      chk("bp_swap_valid", rsp_valid, 1);
      chk("bp_swap_data", rsp_data, 8'h2D);
      chk("bp_swap_addr", addr, 0);
      tick();
      chk("bp_done", rsp_valid, 0);

      // FIFO full while the sequencer is stalled on a read
      rsp_ready = 1'b0;
      push(1'b0, 8'h60, 8'h00);
      repeat (3) tick();
      chk("full_r0_valid", rsp_valid, 1);
      push(1'b0, 8'h61, 8'h00);
      repeat (3) tick();
      chk("full_stall_addr", addr, 8'h61);
      push(1'b1, 8'h70, 8'h01);
      push(1'b0, 8'h70, 8'h00);
      push(1'b1, 8'h71, 8'h02);
      chk("full_ready3", cmd_ready, 1);
      push(1'b0, 8'h71, 8'h00);
      chk("full_ready4", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
      cmd_addr  = 8'h72;
      cmd_data  = 8'h03;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("full_blocked%0d", i), cmd_ready, 0);
         tick();
      end
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      chk("full_busy", busy, 1);
      drain("full");
      check_logs("dir");

      // reset in the strobe cycle with a held response and queued writes
      snap_mem  = model_mem;
      rsp_ready = 1'b0;
      push(1'b0, 8'h20, 8'h00);
      push(1'b1, 8'h30, 8'hC1);
      push(1'b1, 8'h31, 8'hC2);
      push(1'b1, 8'h32, 8'hC3);
      for (int g = 0; g < 20 && !wr; g++) tick();
      chk("rst_pre_wr", wr, 1);
      chk("rst_pre_rspvalid", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rstm_wr", wr, 0);
      chk("rstm_addr", addr, 0);
      chk("rstm_dout", dout, 0);
      chk("rstm_rspvalid", rsp_valid, 0);
      chk("rstm_rspdata", rsp_data, 0);
      chk("rstm_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (10) tick();
      chk("rstm_after_busy", busy, 0);
      chk("rstm_after_ready", cmd_ready, 1);
      chk("rstm_no_writes", wr_log.size(), 0);
      chk("rstm_no_rsp", rsp_log.size(), 0);
      model_mem = snap_mem;
      exp_wr.delete();
      exp_rsp.delete();
      wr_log.delete();
      rsp_log.delete();

      // randomized command stream with random consumer stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      drain("rand");
      check_logs("rand");

`ifdef DBUS_AUTOINC_EN
      // bursts: write wraps the address, read burst returns one rsp per beat
      push_burst(1'b1, 8'hFE, 8'h77, 4'd2);
      drain("bw");
      rand_ready = 1'b1;
      push_burst(1'b0, 8'hFF, 8'h00, 4'd1);
      drain("br");
      check_logs("burst");
`endif

      chk("wr_never_consecutive", wr_double, 0);
      chk("rsp_held_until_ready", rsp_drop, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
